// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit between the EX/MEM register and a multi-cycle,
// word-organised data memory. Turns a RISC-V load/store into a word-aligned
// request with byte enables, stalls the pipeline while the memory is busy and
// returns sign/zero-extended load data.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses skip the memory, pulse misalign,
//               drop stores and return ld_data=0 for loads.
//   undefined : offending low address bits are cleared and the access proceeds;
//               misalign is tied to 0.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   req_read/write  load / store request from EX/MEM (write wins if both)
//   req_addr        byte address; req_wdata store data; req_funct3 size/sign
//   stall           hold upstream pipeline (combinational)
//   ld_data         formatted load result, held until the next load completes
//   ld_valid        one-cycle load-complete strobe
//   misalign        misaligned-access pulse (trap build only)
//   mem_req/we/addr/be/wdata  memory request, held until mem_ready
//   mem_rdata/mem_ready       memory response
module mem_stage_lsu #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  ld_valid,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                r_state, w_next;
  logic                  w_req;
  logic [1:0]            w_size;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_fmt;

  logic [DM_ADDRESS-1:0] r_mem_addr;
  logic [3:0]            r_be;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_we;
  logic                  r_ld;
  logic [1:0]            r_size;
  logic                  r_sgn;
  logic [1:0]            r_off;
  logic [DATA_W-1:0]     r_ld_data;

  assign w_req = req_read | req_write;

  // Request decode: access size, effective lane offset, byte enables, lane data.
  // The offset drops the low bits that a halfword/word cannot use.
  always_comb begin
    w_size  = SZ_W;
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        w_size  = SZ_B;
        w_off   = req_addr[1:0];
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        w_size  = SZ_H;
        w_off   = {req_addr[1], 1'b0};
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  logic r_mis;
  assign w_mis = ((w_size == SZ_H) && req_addr[0]) ||
                 ((w_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign misalign = (r_state == DONE) && r_mis;
`else
  assign misalign = 1'b0;
`endif

  // Load formatting: lane select by offset, then extend.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_fmt  = mem_rdata;
    if (r_size == SZ_B) begin
      w_fmt = {{(DATA_W-8){r_sgn & w_byte[7]}}, w_byte};
    end else if (r_size == SZ_H) begin
      w_fmt = {{(DATA_W-16){r_sgn & w_half[15]}}, w_half};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and stall.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          stall  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          w_next = w_mis ? DONE : BUSY;
`else
          w_next = BUSY;
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ready) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture on accept, load data capture on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_ld       <= 1'b0;
      r_size     <= SZ_W;
      r_sgn      <= 1'b0;
      r_off      <= 2'b00;
      r_ld_data  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis      <= 1'b0;
`endif
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_mem_addr <= {req_addr[DM_ADDRESS-1:2], 2'b00};
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_we       <= req_write;
        r_ld       <= req_read & ~req_write;
        r_size     <= w_size;
        r_sgn      <= ~req_funct3[2];
        r_off      <= w_off;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis      <= w_mis;
        if (w_mis && !req_write) r_ld_data <= '0;
`endif
      end
      if ((r_state == BUSY) && mem_ready && r_ld) r_ld_data <= w_fmt;
    end
  end

  assign mem_req   = (r_state == BUSY);
  assign mem_we    = r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign ld_data   = r_ld_data;
  assign ld_valid  = (r_state == DONE) && r_ld;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid, misalign;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  // observations filled by run_access
  int          o_nstall, o_nreq;
  logic [8:0]  o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata, o_ld;
  logic        o_we, o_ldv, o_mis;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Drives one access from IDLE (entered at posedge+1); returns in the DONE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input logic [31:0] rword, input int waits);
    int  bc;
    bit  done;
    bc = 0; done = 0;
    o_nstall = 0; o_nreq = 0; o_ldv = 0; o_mis = 0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 0; o_ld = '0;
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    mem_rdata = rword; mem_ready = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (cyc > 0 && !stall) begin
        o_ldv = ld_valid; o_mis = misalign; o_ld = ld_data;
        done = 1;
        break;
      end
      if (stall) o_nstall++;
      if (mem_req) begin
        o_nreq++;
        o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        mem_ready = (bc == waits);
        bc++;
      end else begin
        mem_ready = 0;
      end
      @(posedge clk); #1;
      req_read = 0; req_write = 0;
    end
    mem_ready = 0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL access_timeout addr=%h got=no_done want=done", addr);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit seen_req, nz;
    seen_req = 0; nz = 0;
    reset = 0; req_read = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; mem_rdata = 32'hFFFFFFFF; mem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = ~mem_ready;
      @(negedge clk);
      if (mem_req !== 1'b0) seen_req = 1;
      if ({stall, ld_data, ld_valid, misalign, mem_we, mem_addr, mem_be, mem_wdata} !== '0) nz = 1;
    end
    total++;
    if (seen_req) begin bad++; $display("FAIL reset_mem_req got=1 want=0"); end
    total++;
    if (nz) begin bad++; $display("FAIL reset_outputs got=nonzero want=0"); end
    mem_ready = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    run_access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 3);
    total++;
    if ({o_addr, o_be, o_wdata, o_we} !== {9'h010, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      bad++; $display("FAIL sw_req got=%h/%b/%h/%b want=010/1111/deadbeef/1", o_addr, o_be, o_wdata, o_we);
    end
    total++;
    if (o_nstall !== 5) begin bad++; $display("FAIL sw_stall got=%0d want=5", o_nstall); end
    total++;
    if (o_nreq !== 4 || o_ldv !== 1'b0) begin
      bad++; $display("FAIL sw_req_cycles got=%0d/%b want=4/0", o_nreq, o_ldv);
    end
    idle_cycle();
  endtask

  task automatic test_lb();
    run_access(1'b1, 1'b0, 9'h013, 32'h0, 3'b000, 32'h80112233, 0);
    total++;
    if ({o_addr, o_be, o_we} !== {9'h010, 4'b1000, 1'b0}) begin
      bad++; $display("FAIL lb_req got=%h/%b/%b want=010/1000/0", o_addr, o_be, o_we);
    end
    total++;
    if (o_ld !== 32'hFFFFFF80 || o_ldv !== 1'b1) begin
      bad++; $display("FAIL lb_data got=%h/%b want=ffffff80/1", o_ld, o_ldv);
    end
    total++;
    if (o_nstall !== 2) begin bad++; $display("FAIL lb_stall got=%0d want=2", o_nstall); end
    idle_cycle();
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_hold got=%h/%b want=ffffff80/0", ld_data, ld_valid);
    end
  endtask

  task automatic test_half_unsigned();
    run_access(1'b1, 1'b0, 9'h012, 32'h0, 3'b101, 32'h8001ABCD, 1);
    total++;
    if (o_ld !== 32'h00008001 || o_be !== 4'b1100) begin
      bad++; $display("FAIL lhu got=%h/%b want=00008001/1100", o_ld, o_be);
    end
    idle_cycle();
    run_access(1'b1, 1'b0, 9'h010, 32'h0, 3'b001, 32'h8001ABCD, 0);
    total++;
    if (o_ld !== 32'hFFFFABCD || o_be !== 4'b0011) begin
      bad++; $display("FAIL lh got=%h/%b want=ffffabcd/0011", o_ld, o_be);
    end
    idle_cycle();
    run_access(1'b1, 1'b0, 9'h011, 32'h0, 3'b100, 32'h80112233, 0);
    total++;
    if (o_ld !== 32'h00000022 || o_be !== 4'b0010) begin
      bad++; $display("FAIL lbu got=%h/%b want=00000022/0010", o_ld, o_be);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 9'h005, 32'h000000A5, 3'b000, 32'h0, 0);
    total++;
    if ({o_addr, o_be, o_wdata} !== {9'h004, 4'b0010, 32'hA5A5A5A5}) begin
      bad++; $display("FAIL sb_req got=%h/%b/%h want=004/0010/a5a5a5a5", o_addr, o_be, o_wdata);
    end
    // next request presented during DONE must not stall or issue until IDLE
    req_read = 1; req_write = 0; req_addr = 9'h004; req_funct3 = 3'b010;
    #1;
    total++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got=%b/%b want=0/0", stall, mem_req);
    end
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 9'h004, 32'h0, 3'b010, 32'h12345678, 0);
    total++;
    if ({o_addr, o_be, o_ld, o_ldv} !== {9'h004, 4'b1111, 32'h12345678, 1'b1} || o_nstall !== 2) begin
      bad++; $display("FAIL b2b_lw got=%h/%b/%h/%b/%0d want=004/1111/12345678/1/2",
                      o_addr, o_be, o_ld, o_ldv, o_nstall);
    end
    idle_cycle();
  endtask

  task automatic test_both_req();
    run_access(1'b1, 1'b1, 9'h020, 32'h11223344, 3'b010, 32'h99999999, 0);
    total++;
    if ({o_we, o_wdata, o_ldv, o_ld} !== {1'b1, 32'h11223344, 1'b0, 32'h12345678}) begin
      bad++; $display("FAIL both_req got=%b/%h/%b/%h want=1/11223344/0/12345678", o_we, o_wdata, o_ldv, o_ld);
    end
    idle_cycle();
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 9'h006, 32'h0, 3'b010, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (o_nstall !== 1 || o_nreq !== 0 || o_mis !== 1'b1) begin
      bad++; $display("FAIL mis_trap got=%0d/%0d/%b want=1/0/1", o_nstall, o_nreq, o_mis);
    end
    total++;
    if (o_ld !== 32'h0 || o_ldv !== 1'b1) begin
      bad++; $display("FAIL mis_data got=%h/%b want=00000000/1", o_ld, o_ldv);
    end
`else
    total++;
    if ({o_addr, o_be, o_mis} !== {9'h004, 4'b1111, 1'b0} || o_nstall !== 2) begin
      bad++; $display("FAIL mis_fix got=%h/%b/%b/%0d want=004/1111/0/2", o_addr, o_be, o_mis, o_nstall);
    end
    total++;
    if (o_ld !== 32'hCAFEF00D || o_ldv !== 1'b1) begin
      bad++; $display("FAIL mis_data got=%h/%b want=cafef00d/1", o_ld, o_ldv);
    end
`endif
    idle_cycle();
  endtask

  task automatic test_reset_mid_busy();
    req_read = 1; req_write = 0; req_addr = 9'h008; req_funct3 = 3'b010;
    mem_rdata = 32'h55555555; mem_ready = 0;
    @(posedge clk); #1;
    req_read = 0;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_busy_pre got=%b want=1", mem_req); end
    #2; reset = 0; #1;
    total++;
    if ({mem_req, stall, ld_valid, ld_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL rst_busy got=%b/%b/%b/%h want=0/0/0/0", mem_req, stall, ld_valid, ld_data);
    end
    #2; reset = 1;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 9'h008, 32'h0, 3'b010, 32'h0BADF00D, 1);
    total++;
    if (o_nstall !== 3 || o_nreq !== 2 || o_ld !== 32'h0BADF00D) begin
      bad++; $display("FAIL rst_recover got=%0d/%0d/%h want=3/2/0badf00d", o_nstall, o_nreq, o_ld);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb();
    test_half_unsigned();
    test_back_to_back();
    test_both_req();
    test_misalign();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
